instr_queue_alu: RTL and testbench

- Parametrised next-generation instruction register with configurable operand width and storage depth.
- Two access modes: addressed (external write/read pointers) and FIFO (internal pointers, full/empty flow control).
- Each entry stores opcode, operand_a, operand_b and the result, computed at write time.
- Sits between the stimulus driver and the result checker in the lab instruction-register environment.

---
 rtl/instr_queue_alu.sv | 228 ++++++++++++++++++++++
 tb/tb_instr_queue_alu.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/instr_queue_alu.sv
//------------------------------------------------------------------------------
// Module   : instr_queue_alu
// Purpose  : Instruction register with an ALU at the write port. Every entry
//            keeps {opcode, operand_a, operand_b, result, err}, and the result
//            is computed when the entry is written. Entries are reached either
//            through external pointers (addressed mode) or through internal
//            pointers with full/empty flow control (FIFO mode).
// Ports    : clk, reset (async, active-high)
//            mode, load_en, rd_en, opcode, operand_a, operand_b,
//            write_pointer, read_pointer                 -> inputs
//            instruction_word, out_valid, full, empty,
//            count, overflow, underflow, div_err         -> outputs
// Options  : INSTR_SAT_EN - ADD/SUB/MULT results saturate to the signed OPW
//            range and are then sign-extended to 2*OPW bits.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module instr_queue_alu #(
  parameter int OPW   = 32,
  parameter int DEPTH = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 mode,
  input  logic                 load_en,
  input  logic                 rd_en,
  input  logic [2:0]           opcode,
  input  logic [OPW-1:0]       operand_a,
  input  logic [OPW-1:0]       operand_b,
  input  logic [AW-1:0]        write_pointer,
  input  logic [AW-1:0]        read_pointer,
  output logic [3+4*OPW-1:0]   instruction_word,
  output logic                 out_valid,
  output logic                 full,
  output logic                 empty,
  output logic [AW:0]          count,
  output logic                 overflow,
  output logic                 underflow,
  output logic                 div_err
);

  localparam int RW = 2 * OPW;          // result width
  localparam int IW = 3 + 4 * OPW;      // instruction word width
  localparam int EW = IW + 1;           // stored entry: word plus error bit

  localparam logic [AW:0] c_FULL_CNT = (AW + 1)'(DEPTH);

  localparam logic [2:0] c_OP_ZERO  = 3'd0;
  localparam logic [2:0] c_OP_PASSA = 3'd1;
  localparam logic [2:0] c_OP_PASSB = 3'd2;
  localparam logic [2:0] c_OP_ADD   = 3'd3;
  localparam logic [2:0] c_OP_SUB   = 3'd4;
  localparam logic [2:0] c_OP_MULT  = 3'd5;
  localparam logic [2:0] c_OP_DIV   = 3'd6;
  localparam logic [2:0] c_OP_MOD   = 3'd7;

  //----------------------------------------------------------------------------
  // ALU (combinational on the write-side inputs)
  //----------------------------------------------------------------------------
  logic signed [RW-1:0] w_a_ext;
  logic signed [RW-1:0] w_b_ext;
  logic signed [RW-1:0] w_raw;
  logic signed [RW-1:0] w_result;
  logic                 w_err;
  logic                 w_b_zero;

  // Operands are widened before arithmetic, so the full product and the
  // MIN/-1 quotient are exact in RW bits.
  assign w_a_ext  = {{OPW{operand_a[OPW-1]}}, operand_a};
  assign w_b_ext  = {{OPW{operand_b[OPW-1]}}, operand_b};
  assign w_b_zero = (operand_b == '0);

  always_comb begin
    w_raw = '0;
    w_err = 1'b0;
    case (opcode)
      c_OP_ZERO:  w_raw = '0;
      c_OP_PASSA: w_raw = w_a_ext;
      c_OP_PASSB: w_raw = w_b_ext;
      c_OP_ADD:   w_raw = w_a_ext + w_b_ext;
      c_OP_SUB:   w_raw = w_a_ext - w_b_ext;
      c_OP_MULT:  w_raw = w_a_ext * w_b_ext;
      c_OP_DIV: begin
        if (w_b_zero) w_err = 1'b1;
        else          w_raw = w_a_ext / w_b_ext;
      end
      c_OP_MOD: begin
        if (w_b_zero) w_err = 1'b1;
        else          w_raw = w_a_ext % w_b_ext;
      end
      default:    w_raw = '0;
    endcase
  end

`ifdef INSTR_SAT_EN
  localparam logic signed [RW-1:0] c_SAT_MAX = {{(OPW+1){1'b0}}, {(OPW-1){1'b1}}};
  localparam logic signed [RW-1:0] c_SAT_MIN = {{(OPW+1){1'b1}}, {(OPW-1){1'b0}}};
  logic w_sat_op;

  assign w_sat_op = (opcode == c_OP_ADD) || (opcode == c_OP_SUB) || (opcode == c_OP_MULT);

  always_comb begin
    w_result = w_raw;
    if (w_sat_op) begin
      if (w_raw > c_SAT_MAX)      w_result = c_SAT_MAX;
      else if (w_raw < c_SAT_MIN) w_result = c_SAT_MIN;
    end
  end
`else
  assign w_result = w_raw;
`endif

  //----------------------------------------------------------------------------
  // Access control
  //----------------------------------------------------------------------------
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW:0]   count_q, count_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;
  logic          mode_q;
  logic [IW-1:0] iw_q;
  logic          valid_q;
  logic          derr_q;
  logic [EW-1:0] mem_q [DEPTH];

  logic          w_mode_chg;
  logic          w_push;
  logic          w_pop;
  logic [AW-1:0] w_waddr;
  logic [AW-1:0] w_raddr;
  logic [EW-1:0] w_entry;
  logic [EW-1:0] w_rd_entry;

  // The first cycle in a new mode only resets the pointers; requests are ignored.
  assign w_mode_chg = (mode != mode_q);
  assign w_push     = !w_mode_chg && load_en && (!mode || !full_q);
  assign w_pop      = !w_mode_chg && rd_en   && (!mode || !empty_q);
  assign w_waddr    = mode ? wptr_q : write_pointer;
  assign w_raddr    = mode ? rptr_q : read_pointer;
  assign w_entry    = {opcode, operand_a, operand_b, w_result, w_err};
  // Pre-edge array contents, which gives read-before-write on same address.
  assign w_rd_entry = mem_q[w_raddr];

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    full_d  = full_q;
    empty_d = empty_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    if (w_mode_chg) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
      full_d  = 1'b0;
      empty_d = 1'b1;
    end else if (mode) begin
      if (w_push) wptr_d = wptr_q + 1'b1;
      if (w_pop)  rptr_d = rptr_q + 1'b1;
      case ({w_push, w_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
      full_d  = (count_d == c_FULL_CNT);
      empty_d = (count_d == '0);
      ovf_d   = ovf_q | (load_en & full_q);
      unf_d   = unf_q | (rd_en & empty_q);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (w_push) begin
      mem_q[w_waddr] <= w_entry;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      mode_q  <= 1'b0;
      iw_q    <= '0;
      valid_q <= 1'b0;
      derr_q  <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      full_q  <= full_d;
      empty_q <= empty_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      mode_q  <= mode;
      valid_q <= w_pop;
      // Output word holds until the next accepted read.
      if (w_pop) begin
        iw_q   <= w_rd_entry[EW-1:1];
        derr_q <= w_rd_entry[0];
      end
    end
  end

  assign instruction_word = iw_q;
  assign out_valid        = valid_q;
  assign full             = full_q;
  assign empty            = empty_q;
  assign count            = count_q;
  assign overflow         = ovf_q;
  assign underflow        = unf_q;
  assign div_err          = derr_q;

endmodule

`default_nettype wire

// File: tb/tb_instr_queue_alu.sv
//------------------------------------------------------------------------------
// Module   : tb_instr_queue_alu
// Purpose  : Directed self-checking bench for instr_queue_alu (OPW=32,
//            DEPTH=32). Follows INSTR_SAT_EN for the saturation expectation.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_instr_queue_alu;

  logic         clk = 1'b0;
  logic         reset;
  logic         mode;
  logic         load_en;
  logic         rd_en;
  logic [2:0]   opcode;
  logic [31:0]  operand_a;
  logic [31:0]  operand_b;
  logic [4:0]   write_pointer;
  logic [4:0]   read_pointer;
  logic [130:0] instruction_word;
  logic         out_valid;
  logic         full;
  logic         empty;
  logic [5:0]   count;
  logic         overflow;
  logic         underflow;
  logic         div_err;

  int n_pass  = 0;
  int n_total = 0;

  instr_queue_alu dut (
    .clk              (clk),
    .reset            (reset),
    .mode             (mode),
    .load_en          (load_en),
    .rd_en            (rd_en),
    .opcode           (opcode),
    .operand_a        (operand_a),
    .operand_b        (operand_b),
    .write_pointer    (write_pointer),
    .read_pointer     (read_pointer),
    .instruction_word (instruction_word),
    .out_valid        (out_valid),
    .full             (full),
    .empty            (empty),
    .count            (count),
    .overflow         (overflow),
    .underflow        (underflow),
    .div_err          (div_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [130:0] obs, input logic [130:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                    input logic [4:0] ptr);
    opcode = op; operand_a = a; operand_b = b; write_pointer = ptr;
    load_en = 1'b1;
    step();
    load_en = 1'b0;
  endtask

  task automatic rd(input logic [4:0] ptr);
    read_pointer = ptr;
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [63:0] sat_exp;
    reset = 1'b1; mode = 1'b0; load_en = 1'b0; rd_en = 1'b0;
    opcode = '0; operand_a = '0; operand_b = '0;
    write_pointer = '0; read_pointer = '0;
    step(); step();

    // Reset state
    chk("rst_iw",    instruction_word, '0);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_full",  full, 1'b0);
    chk("rst_empty", empty, 1'b1);
    chk("rst_count", count, 6'd0);
    chk("rst_flags", {overflow, underflow, div_err}, 3'b000);
    reset = 1'b0;
    step();

    // Addressed write/read: ADD 5 + -3 at ptr 7
    wr(3'd3, 32'd5, 32'hFFFF_FFFD, 5'd7);
    rd(5'd7);
    chk("addr_valid", out_valid, 1'b1);
    chk("addr_op",    instruction_word[130:128], 3'd3);
    chk("addr_res",   instruction_word[63:0], 64'd2);
    step();
    chk("addr_valid_drop", out_valid, 1'b0);
    chk("addr_hold",  instruction_word[63:0], 64'd2);

    // Same-cycle write and read at ptr 7 returns old contents
    opcode = 3'd4; operand_a = 32'd9; operand_b = 32'd4; write_pointer = 5'd7;
    read_pointer = 5'd7; load_en = 1'b1; rd_en = 1'b1;
    step();
    load_en = 1'b0; rd_en = 1'b0;
    chk("rbw_old", instruction_word[63:0], 64'd2);
    rd(5'd7);
    chk("rbw_new", instruction_word[63:0], 64'd5);

    // Divide by zero and signed MOD
    wr(3'd6, 32'd10, 32'd0, 5'd0);
    rd(5'd0);
    chk("div0_res", instruction_word[63:0], 64'd0);
    chk("div0_err", div_err, 1'b1);
    wr(3'd7, 32'hFFFF_FFF9, 32'd2, 5'd1);
    rd(5'd1);
    chk("mod_res", instruction_word[63:0], 64'hFFFF_FFFF_FFFF_FFFF);
    chk("mod_err", div_err, 1'b0);
    wr(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd3);
    rd(5'd3);
    chk("div_neg", instruction_word[63:0], 64'hFFFF_FFFF_FFFF_FFFD);
    wr(3'd5, 32'hFFFF_FFFD, 32'd4, 5'd4);
    rd(5'd4);
    chk("mult_neg", instruction_word[63:0], 64'hFFFF_FFFF_FFFF_FFF4);
    wr(3'd1, 32'h8000_0000, 32'd1, 5'd5);
    rd(5'd5);
    chk("passa_sext", instruction_word[63:0], 64'hFFFF_FFFF_8000_0000);

    // Saturation / full-precision MULT
`ifdef INSTR_SAT_EN
    sat_exp = 64'h0000_0000_7FFF_FFFF;
`else
    sat_exp = 64'h0000_0000_FFFF_FFFE;
`endif
    wr(3'd5, 32'h7FFF_FFFF, 32'd2, 5'd2);
    rd(5'd2);
    chk("mult_sat", instruction_word[63:0], sat_exp);

    // Switch to FIFO: the transition cycle ignores the push
    mode = 1'b1; opcode = 3'd3; operand_a = 32'd77; operand_b = 32'd0; load_en = 1'b1;
    step();
    load_en = 1'b0;
    chk("modechg_count", count, 6'd0);
    chk("modechg_empty", empty, 1'b1);

    // Fill the FIFO
    opcode = 3'd3; operand_b = 32'd100; load_en = 1'b1;
    for (int i = 0; i < 32; i++) begin
      operand_a = i;
      step();
    end
    chk("fill_count", count, 6'd32);
    chk("fill_full",  full, 1'b1);
    chk("fill_ovf0",  overflow, 1'b0);
    operand_a = 32'd999;
    step();
    load_en = 1'b0;
    chk("ovf_flag",  overflow, 1'b1);
    chk("ovf_count", count, 6'd32);

    // Drain: push order preserved, overflowing push left no trace
    rd_en = 1'b1;
    for (int i = 0; i < 32; i++) begin
      step();
      chk("pop_valid", out_valid, 1'b1);
      chk("pop_res",   instruction_word[63:0], 64'(i + 100));
    end
    rd_en = 1'b0;
    step();
    chk("drain_empty", empty, 1'b1);
    chk("drain_full",  full, 1'b0);
    chk("drain_count", count, 6'd0);

    // Pop while empty
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    chk("unf_flag",  underflow, 1'b1);
    chk("unf_valid", out_valid, 1'b0);
    chk("unf_hold",  instruction_word[63:0], 64'd131);
    chk("ovf_sticky", overflow, 1'b1);

    // Simultaneous push + pop at count 5
    load_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      operand_a = 200 + i;
      step();
    end
    chk("five_count", count, 6'd5);
    operand_a = 32'd205; rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    chk("pp_count", count, 6'd5);
    chk("pp_valid", out_valid, 1'b1);
    chk("pp_res",   instruction_word[63:0], 64'd300);
    for (int i = 0; i < 5; i++) begin
      operand_a = 206 + i;
      step();
    end
    load_en = 1'b0;
    chk("ten_count", count, 6'd10);

    // Asynchronous reset mid-cycle takes effect immediately
    #2 reset = 1'b1;
    #1;
    chk("arst_count", count, 6'd0);
    chk("arst_empty", empty, 1'b1);
    chk("arst_iw",    instruction_word, '0);
    chk("arst_flags", {overflow, underflow, div_err, out_valid, full}, 5'b00000);
    step();
    reset = 1'b0;
    mode = 1'b0;
    step();
    rd(5'd7);
    chk("arst_mem_cleared", instruction_word, '0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
